// File: rtl/aes_p.sv
// AES-128 board self-test: encrypts a fixed FIPS-197 vector, decrypts it back, flags both results
// and drives six 7-segment digits. Define AES_P_HEX_DISPLAY_EN for hex instead of decimal digits.
package aes_p_pkg;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0, which the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gm(p, p);
      r = gm(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv ? isbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    return o;
  endfunction

  // State byte r+4c sits at bits [127-8*(r+4c) -: 8] (column-major, as FIPS-197 loads it).
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        int sc;
        sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*sc) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   k [4];
    k = inv ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
      for (int j = 0; j < 4; j++) begin
        logic [7:0] b;
        b = '0;
        for (int t = 0; t < 4; t++) b ^= gm(a[(j+t)%4], k[t]);
        o[127-8*(j+4*c) -: 8] = b;
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [4:0] i);
    case (i)
      5'd1: return 8'h01;  5'd2: return 8'h02;  5'd3: return 8'h04;  5'd4: return 8'h08;
      5'd5: return 8'h10;  5'd6: return 8'h20;  5'd7: return 8'h40;  5'd8: return 8'h80;
      5'd9: return 8'h1b;  5'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] key_core(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ key_core(k[31:0], rc);
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one schedule step so decryption can walk the round keys backwards.
  function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    return {k[127:96] ^ key_core(p3, rc), p1, p2, p3};
  endfunction
endpackage

module aes_enc128
  import aes_p_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] din,
  output logic [127:0] dout,
  output logic         done
);
  logic [127:0] st, rk, rk_n, rnd;
  logic [3:0]   cnt;
  logic         busy;

  always_comb begin
    rk_n = next_key(rk, rcon({1'b0, cnt} + 5'd1));
    rnd  = shift_rows(sub_bytes(st, 1'b0), 1'b0);
    if (cnt != 4'd9) rnd = mix_columns(rnd, 1'b0);
    rnd ^= rk_n;
  end

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '0; rk <= '0; cnt <= '0; busy <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        st <= din ^ key; rk <= key; cnt <= '0; busy <= 1'b1;
      end else if (busy) begin
        st  <= rnd;
        rk  <= rk_n;
        cnt <= cnt + 4'd1;
        if (cnt == 4'd9) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign dout = st;
endmodule

module aes_dec128
  import aes_p_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] din,
  output logic [127:0] dout,
  output logic         done
);
  // Cycles 0..9 expand to the last round key; cycles 10..19 run the inverse rounds.
  logic [127:0] st, rk, rk_f, rk_b, rnd;
  logic [4:0]   cnt;
  logic         busy;

  always_comb begin
    rk_f = next_key(rk, rcon(cnt + 5'd1));
    rk_b = prev_key(rk, rcon(5'd20 - cnt));
    rnd  = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rk_b;
    if (cnt != 5'd19) rnd = mix_columns(rnd, 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '0; rk <= '0; cnt <= '0; busy <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        st <= din; rk <= key; cnt <= '0; busy <= 1'b1;
      end else if (busy) begin
        cnt <= cnt + 5'd1;
        if (cnt < 5'd10) begin
          rk <= rk_f;
          if (cnt == 5'd9) st <= st ^ rk_f;
        end else begin
          rk <= rk_b;
          st <= rnd;
          if (cnt == 5'd19) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

  assign dout = st;
endmodule

module aes_p #(
  parameter logic [127:0] PT_INIT  = 128'h00112233445566778899aabbccddeeff,
  parameter logic [127:0] KEY_INIT = 128'h000102030405060708090a0b0c0d0e0f,
  parameter logic [127:0] CT_EXP   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
  parameter int           TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set1,
  input  logic       set2,
  output logic       e128,
  output logic       d128,
  output logic [6:0] segIn_1,
  output logic [6:0] segIn_2,
  output logic [6:0] segIn_3,
  output logic [6:0] segOut_1,
  output logic [6:0] segOut_2,
  output logic [6:0] segOut_3
);
  typedef enum logic [1:0] {IDLE, ENC, DEC, DONE} state_t;
  localparam int TW = $clog2(TIMEOUT + 2);

  state_t         state, state_n;
  logic           set1_q, start, timeout;
  logic           enc_start, dec_start, enc_done, dec_done;
  logic [127:0]   enc_dout, dec_dout, ct_reg;
  logic [7:0]     dec_reg;
  logic [TW-1:0]  timer;

  aes_enc128 u_enc (.clk(clk), .rst(rst), .start(enc_start), .key(KEY_INIT), .din(PT_INIT),
                    .dout(enc_dout), .done(enc_done));
  aes_dec128 u_dec (.clk(clk), .rst(rst), .start(dec_start), .key(KEY_INIT), .din(ct_reg),
                    .dout(dec_dout), .done(dec_done));

  assign start   = set1 & ~set1_q;
  assign timeout = (timer >= TW'(TIMEOUT));

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = ENC;
      ENC:  if (enc_done) state_n = DEC; else if (timeout) state_n = DONE;
      DEC:  if (dec_done || timeout) state_n = DONE;
      DONE: if (!set1) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; set1_q <= 1'b0; enc_start <= 1'b0; dec_start <= 1'b0;
      timer <= '0; ct_reg <= '0; dec_reg <= '0; e128 <= 1'b0; d128 <= 1'b0;
    end else begin
      state     <= state_n;
      set1_q    <= set1;
      enc_start <= (state == IDLE) && start;
      dec_start <= (state == ENC) && enc_done;
      if (state_n != state)                timer <= '0;
      else if (state == ENC || state == DEC) timer <= timer + 1'b1;
      if (state == ENC && enc_done) begin
        ct_reg <= enc_dout;
        e128   <= (enc_dout == CT_EXP);
      end
      if (state == DEC && dec_done) begin
        dec_reg <= dec_dout[7:0];
        d128    <= (dec_dout == PT_INIT);
      end
      if (state == DONE && state_n == IDLE) begin
        e128 <= 1'b0;
        d128 <= 1'b0;
      end
    end
  end

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;  4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;  4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;  4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;  4'ha: return 7'b0001000;  4'hb: return 7'b0000011;
      4'hc: return 7'b1000110;  4'hd: return 7'b0100001;  4'he: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [20:0] digits(input logic [7:0] b);
`ifdef AES_P_HEX_DISPLAY_EN
    return {7'b1111111, seg(b[7:4]), seg(b[3:0])};
`else
    return {seg(4'(b / 8'd100)), seg(4'((b / 8'd10) % 8'd10)), seg(4'(b % 8'd10))};
`endif
  endfunction

  assign {segIn_1, segIn_2, segIn_3}    = digits(PT_INIT[7:0]);
  assign {segOut_1, segOut_2, segOut_3} = digits(set2 ? dec_reg : ct_reg[7:0]);
endmodule

// File: tb/tb_aes_p.sv
// Scoreboard bench for aes_p: stimulus queues expected flags/digits, a negedge monitor compares.
module tb_aes_p;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst, set1, set2;
  logic e128, d128;
  logic [6:0] segIn_1, segIn_2, segIn_3, segOut_1, segOut_2, segOut_3;

  aes_p dut (.clk(clk), .rst(rst), .set1(set1), .set2(set2), .e128(e128), .d128(d128),
             .segIn_1(segIn_1), .segIn_2(segIn_2), .segIn_3(segIn_3),
             .segOut_1(segOut_1), .segOut_2(segOut_2), .segOut_3(segOut_3));

  always #5 clk = ~clk;

  localparam logic [6:0] S0 = 7'b1000000, S2 = 7'b0100100, S5 = 7'b0010010, S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000, SF = 7'b0001110, SBL = 7'b1111111;
`ifdef AES_P_HEX_DISPLAY_EN
  localparam logic [20:0] D_IN = {SBL, SF, SF}, D_CT = {SBL, S5, SA};
  localparam logic [20:0] D_FF = {SBL, SF, SF}, D_ZERO = {SBL, S0, S0};
`else
  localparam logic [20:0] D_IN = {S2, S5, S5}, D_CT = {S0, S9, S0};
  localparam logic [20:0] D_FF = {S2, S5, S5}, D_ZERO = {S0, S0, S0};
`endif

  typedef struct {
    string       name;
    logic        e, d;
    logic [20:0] seg_in, seg_out;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check({x.name, ".e128"}, {6'b0, e128}, {6'b0, x.e});
      check({x.name, ".d128"}, {6'b0, d128}, {6'b0, x.d});
      check({x.name, ".segIn_1"}, segIn_1, x.seg_in[20:14]);
      check({x.name, ".segIn_2"}, segIn_2, x.seg_in[13:7]);
      check({x.name, ".segIn_3"}, segIn_3, x.seg_in[6:0]);
      check({x.name, ".segOut_1"}, segOut_1, x.seg_out[20:14]);
      check({x.name, ".segOut_2"}, segOut_2, x.seg_out[13:7]);
      check({x.name, ".segOut_3"}, segOut_3, x.seg_out[6:0]);
    end
  end

  task automatic expect_out(input string name, input logic e, input logic d, input logic [20:0] o);
    exp_t x;
    x.name = name; x.e = e; x.d = d; x.seg_in = D_IN; x.seg_out = o;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait; on expiry the following expectation of a set flag fails by itself.
  task automatic wait_flag(input bit want_d);
    for (int i = 0; i < 2 * TIMEOUT; i++) begin
      tick(1);
      if ((want_d ? d128 : e128) === 1'b1) return;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; set1 = 1'b0; set2 = 1'b0;
    tick(2);
    rst = 1'b0;
    expect_out("reset", 1'b0, 1'b0, D_ZERO);
    tick(1);

    set1 = 1'b1;
    wait_flag(1'b0);
    expect_out("run1_enc", 1'b1, 1'b0, D_CT);
    wait_flag(1'b1);
    expect_out("run1_dec", 1'b1, 1'b1, D_CT);
    tick(1);
    set2 = 1'b1;
    expect_out("sel_dec", 1'b1, 1'b1, D_FF);
    tick(1);
    set2 = 1'b0;
    expect_out("sel_ct", 1'b1, 1'b1, D_CT);
    tick(1);

    set1 = 1'b0;
    tick(1);
    expect_out("clear", 1'b0, 1'b0, D_CT);
    tick(2);

    set1 = 1'b1;
    wait_flag(1'b0);
    wait_flag(1'b1);
    expect_out("run2", 1'b1, 1'b1, D_CT);
    tick(1);
    set1 = 1'b0;
    tick(2);
    expect_out("idle2", 1'b0, 1'b0, D_CT);

    set1 = 1'b1;
    tick(3);
    rst  = 1'b1;
    set1 = 1'b0;
    tick(1);
    rst = 1'b0;
    expect_out("rst_mid", 1'b0, 1'b0, D_ZERO);
    tick(30);
    expect_out("rst_quiet", 1'b0, 1'b0, D_ZERO);

    set2 = 1'b1;
    set1 = 1'b1;
    tick(1);
    set1 = 1'b0;
    wait_flag(1'b0);
    expect_out("pulse_enc", 1'b1, 1'b0, D_ZERO);
    wait_flag(1'b1);
    expect_out("pulse_dec", 1'b1, 1'b1, D_FF);
    tick(1);
    expect_out("pulse_clear", 1'b0, 1'b0, D_FF);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
